// File: rtl/fib_request_scheduler.sv
// rtl/fib_request_scheduler.sv - two-requester round-robin Fibonacci F(n) mod 2^16 scheduler
// Optional overflow flag output rsp_ovf enabled by defining FIB_OVERFLOW_FLAG_EN.
module fib_request_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [4:0]  req_idx0,
  input  logic [4:0]  req_idx1,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_num,
`ifdef FIB_OVERFLOW_FLAG_EN
  output logic        rsp_ovf,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q;
  logic        ptr_q;
  logic [15:0] a_q, b_q;
  logic [4:0]  rem_q;
  logic        id_q;
  logic [15:0] num_q;
  logic        valid_q;
  logic        busy_q;
  logic [1:0]  grant_d;
  logic [4:0]  sel_idx_d;

`ifdef FIB_OVERFLOW_FLAG_EN
  // ovf_a_q/ovf_b_q mark that the true value held in a_q/b_q has exceeded 16 bits
  logic        ovf_a_q, ovf_b_q, ovf_q;
  logic [16:0] sum_d;
  assign sum_d   = {1'b0, a_q} + {1'b0, b_q};
  assign rsp_ovf = ovf_q;
`else
  logic [15:0] sum_d;
  assign sum_d = a_q + b_q;
`endif

  always_comb begin
    grant_d = 2'b00;
    if (state_q == S_IDLE) begin
      case (req_valid)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = ptr_q ? 2'b10 : 2'b01;
        default: grant_d = 2'b00;
      endcase
    end
  end

  assign sel_idx_d = grant_d[1] ? req_idx1 : req_idx0;
  assign req_ready = grant_d;
  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_num   = num_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      a_q     <= 16'd1;
      b_q     <= 16'd1;
      rem_q   <= 5'd0;
      id_q    <= 1'b0;
      num_q   <= 16'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FIB_OVERFLOW_FLAG_EN
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_d != 2'b00) begin
            id_q   <= grant_d[1];
            a_q    <= 16'd1;
            b_q    <= 16'd1;
            rem_q  <= sel_idx_d - 5'd1;
            busy_q <= 1'b1;
`ifdef FIB_OVERFLOW_FLAG_EN
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
            if (sel_idx_d >= 5'd2) begin
              state_q <= S_RUN;
            end else begin
              // F(0)=0 and F(1)=1 are ready immediately
              state_q <= S_DONE;
              valid_q <= 1'b1;
              num_q   <= {15'd0, sel_idx_d[0]};
            end
          end
        end
        S_RUN: begin
          a_q   <= b_q;
          b_q   <= sum_d[15:0];
          rem_q <= rem_q - 5'd1;
`ifdef FIB_OVERFLOW_FLAG_EN
          ovf_a_q <= ovf_b_q;
          ovf_b_q <= ovf_a_q | ovf_b_q | sum_d[16];
`endif
          if (rem_q == 5'd1) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            num_q   <= b_q;
`ifdef FIB_OVERFLOW_FLAG_EN
            ovf_q   <= ovf_b_q;
`endif
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= ~id_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_request_scheduler.sv
// tb/tb_fib_request_scheduler.sv - scoreboard bench for fib_request_scheduler
module tb_fib_request_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [4:0]  req_idx0 = 5'd0;
  logic [4:0]  req_idx1 = 5'd0;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [15:0] rsp_num;
  logic        busy;
`ifdef FIB_OVERFLOW_FLAG_EN
  logic        rsp_ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        id;
    logic [15:0] num;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  // Reference model: 0 idle, 1 computing, 2 result presented
  int   phase  = 0;
  int   wait_n = 0;
  logic m_ptr  = 1'b0;
  logic m_id   = 1'b0;

  always #5 clk = ~clk;

  fib_request_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_idx0  (req_idx0),
    .req_idx1  (req_idx1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_num   (rsp_num),
`ifdef FIB_OVERFLOW_FLAG_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  function automatic exp_t ref_fib(logic id, int n);
    longint f0 = 0;
    longint f1 = 1;
    longint t;
    exp_t   r;
    for (int k = 0; k < n; k++) begin
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
    r.id  = id;
    r.num = 16'(f0);
    r.ovf = (f0 >= 65536);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(logic r, logic [1:0] v, logic [4:0] i0, logic [4:0] i1, logic rr);
    logic [1:0] g;
    int         n;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_idx0  = i0;
    req_idx1  = i1;
    rsp_ready = rr;
    g = 2'b00;
    if (phase == 0) g = (v == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : v;
    #1;
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
    if (r) begin
      phase = 0;
      m_ptr = 1'b0;
      sb.delete();
    end else if (phase == 0 && g != 2'b00) begin
      n    = g[1] ? int'(i1) : int'(i0);
      m_id = g[1];
      sb.push_back(ref_fib(m_id, n));
      wait_n = (n < 2) ? 0 : n - 1;
      phase  = (wait_n == 0) ? 2 : 1;
    end else if (phase == 1) begin
      wait_n--;
      if (wait_n == 0) phase = 2;
    end else if (phase == 2 && rr) begin
      phase = 0;
      m_ptr = !m_id;
    end
  endtask

  task automatic idle(int k, logic rr);
    repeat (k) step(1'b0, 2'b00, 5'($urandom), 5'($urandom), rr);
  endtask

  // Monitor: any presented response must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rsp_num=%0d with no request outstanding", rsp_num);
        end else begin
          chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          chk("rsp_num", 32'(rsp_num), 32'(sb[0].num));
`ifdef FIB_OVERFLOW_FLAG_EN
          chk("rsp_ovf", 32'(rsp_ovf), 32'(sb[0].ovf));
`endif
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_num", 32'(rsp_num), 32'd0);
`ifdef FIB_OVERFLOW_FLAG_EN
    chk("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif

    step(1'b0, 2'b01, 5'd10, 5'd0, 1'b1);
    idle(12, 1'b1);

    repeat (24) step(1'b0, 2'b11, 5'd5, 5'd7, 1'b1);
    idle(3, 1'b1);

    step(1'b0, 2'b01, 5'd0, 5'd9, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 2'b10, 5'd3, 5'd1, 1'b1);
    idle(3, 1'b1);

    step(1'b0, 2'b01, 5'd24, 5'd0, 1'b1);
    idle(26, 1'b1);
    step(1'b0, 2'b10, 5'd0, 5'd25, 1'b1);
    idle(27, 1'b1);

    step(1'b0, 2'b01, 5'd12, 5'd0, 1'b0);
    idle(16, 1'b0);
    idle(2, 1'b1);

    step(1'b0, 2'b10, 5'd0, 5'd20, 1'b1);
    idle(6, 1'b1);
    step(1'b1, 2'b00, 5'd0, 5'd0, 1'b1);
    step(1'b0, 2'b01, 5'd3, 5'd0, 1'b1);
    idle(5, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0), 2'($urandom), 5'($urandom), 5'($urandom),
           ($urandom_range(9) < 7));
    end

    idle(40, 1'b1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
